// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit shift-add multiplier: operand width and
// the controller state encoding, reused by the AQ register and ripple adder.
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/mult_controller_if.sv
// Control bundle between the multiplier sequencer and the AQ register/adder
// datapath. The master modport is the sequencer; the slave modport is the datapath side.
interface mult_controller_if #(
  parameter int CNT_W = $clog2(mult_pkg::MULT_WIDTH)
) ();

  // Handshake: start is a level request that is only sampled while idle; there is no
  // ready, busy covers LOAD through the final SHIFT and done pulses for one cycle after it.
  logic                  start;
  logic                  q0;
  logic                  load;
  logic                  add;
  logic                  shift;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      count;
  mult_pkg::ctrl_state_t state;

  modport master (
    input  start, q0,
    output load, add, shift, busy, done, count, state
  );

  modport slave (
    output start, q0,
    input  load, add, shift, busy, done, count, state
  );

endinterface

// File: rtl/mult_controller.sv
// Sequencing FSM for the shift-add multiplier: load, then one ADD/SHIFT pair
// per multiplier bit, then a one-cycle done pulse. Latency is operand-independent.
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  mult_controller_if.master  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Count is cleared on entry to LOAD so it already reads 0 during the LOAD cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        count_d = '0;
        state_d = ADD;
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (count_q == LAST) begin
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // ADD with q0 = 0 is a deliberate idle cycle so every iteration costs two cycles.
  always_comb begin
    bus.load  = 1'b0;
    bus.add   = 1'b0;
    bus.shift = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      LOAD: begin
        bus.load = 1'b1;
        bus.busy = 1'b1;
      end
      ADD: begin
        bus.add  = bus.q0;
        bus.busy = 1'b1;
      end
      SHIFT: begin
        bus.shift = 1'b1;
        bus.busy  = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.count = count_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: models the AQ register and adder around the
// sequencer and checks cycle-exact control timing and the final product.
module tb_mult_controller;
  import mult_pkg::*;

  localparam int W = MULT_WIDTH;

  logic         clock = 1'b0;
  logic         reset;
  int           total = 0;
  int           bad   = 0;
  logic [2*W:0] aq    = '0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;

  mult_controller_if bus ();

  mult_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Datapath model: {C, A, Q} register with the adder feeding C/A.
  assign bus.q0 = aq[0];

  always @(posedge clock) begin
    if (bus.load)       aq <= {1'b0, {W{1'b0}}, mplier};
    else if (bus.add)   aq[2*W:W] <= {1'b0, aq[2*W-1:W]} + {1'b0, mcand};
    else if (bus.shift) aq <= {1'b0, aq[2*W:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs at cycle c after start was sampled at edge 0.
  // ctrl bits are {load, add, shift, busy, done}.
  task automatic expect_cycle(input int c, input logic [W-1:0] m,
                              output logic [4:0] ctrl, output int cnt,
                              output ctrl_state_t st);
    int it;
    ctrl = 5'b00000;
    cnt  = W - 1;
    st   = IDLE;
    if (c == 1 || c == 2*W + 4) begin
      ctrl = 5'b10010;
      cnt  = 0;
      st   = LOAD;
    end else if (c >= 2 && c <= 2*W + 1) begin
      it  = (c - 2) / 2;
      cnt = it;
      if (c % 2 == 0) begin
        st   = ADD;
        ctrl = {1'b0, m[it], 1'b0, 1'b1, 1'b0};
      end else begin
        st   = SHIFT;
        ctrl = 5'b00110;
      end
    end else if (c == 2*W + 2) begin
      st   = DONE;
      ctrl = 5'b00001;
    end
  endtask

  // mode 0: single start pulse; 1: extra start pulses while busy/done; 2: start held.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] a,
                        input int mode, input int abort_at);
    int          last;
    int          ecnt;
    logic [4:0]  ectrl;
    logic [4:0]  octrl;
    ctrl_state_t est;
    mplier    = m;
    mcand     = a;
    bus.start = 1'b1;
    @(posedge clock);
    last = (mode == 2) ? 2*W + 4 : 2*W + 3;
    for (int c = 1; c <= last; c++) begin
      @(negedge clock);
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort ctrl", {27'd0, bus.load, bus.add, bus.shift, bus.busy, bus.done}, 32'd0);
        check("abort state", 32'(bus.state), 32'(IDLE));
        check("abort count", 32'(bus.count), 32'd0);
        return;
      end
      expect_cycle(c, m, ectrl, ecnt, est);
      octrl = {bus.load, bus.add, bus.shift, bus.busy, bus.done};
      check($sformatf("ctrl m=%0h c%0d", m, c), 32'(octrl), 32'(ectrl));
      check($sformatf("count m=%0h c%0d", m, c), 32'(bus.count), 32'(ecnt));
      check($sformatf("state m=%0h c%0d", m, c), 32'(bus.state), 32'(est));
      check($sformatf("excl c%0d", c), 32'($countones({bus.load, bus.add, bus.shift}) <= 1), 32'd1);
      if (c == 2*W + 2)
        check($sformatf("product %0h*%0h", a, m), 32'(aq[2*W-1:0]), int'(a) * int'(m));
      case (mode)
        1:       bus.start = (c == 5 || c == 2*W + 1 || c == 2*W + 2);
        2:       bus.start = (c <= 2*W + 3);
        default: bus.start = 1'b0;
      endcase
    end
  endtask

  initial begin
    logic seen;

    // Reset with start already high: everything idle, start ignored.
    reset     = 1'b1;
    bus.start = 1'b1;
    #2;
    check("reset ctrl", {27'd0, bus.load, bus.add, bus.shift, bus.busy, bus.done}, 32'd0);
    check("reset state", 32'(bus.state), 32'(IDLE));
    check("reset count", 32'(bus.count), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("held reset state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;

    // Release with start high: LOAD on the first edge.
    run_op(8'b01110111, 8'b01010101, 0, 0);
    run_op(8'h00, W'($urandom_range(0, 255)), 0, 0);
    run_op(8'hFF, 8'hFF, 0, 0);
    run_op(W'($urandom), W'($urandom), 1, 0);
    run_op(W'($urandom), W'($urandom), 2, 0);

    seen = 1'b0;
    for (int k = 0; k < 2*W + 4 && !seen; k++) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
    end
    check("held second done", 32'(seen), 32'd1);
    @(negedge clock);

    // Abort mid-operation, then a fresh full-latency run.
    run_op(W'($urandom), W'($urandom), 0, 9);
    @(posedge clock);
    @(negedge clock);
    check("post abort state", 32'(bus.state), 32'(IDLE));
    check("post abort done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    run_op(W'($urandom), W'($urandom), 0, 0);

    for (int n = 0; n < 6; n++)
      run_op(W'($urandom), W'($urandom), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
